uart_echo_ctrl: RTL and testbench

- Loopback controller between the receive path (UART_Rx) and the transmit path (UART_Tx).
- Each byte received on the rx_val/rx_data interface is queued in a small FIFO.
- Queued bytes are replayed to the transmitter one at a time, using a tx_val/busy handshake.
- This replaces the manual tx_val sequencing currently done in the echo bench, so the echo works standalone on hardware with back-to-back received bytes.

---
 rtl/uart_echo_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_echo_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_ctrl.sv
// rtl/uart_echo_ctrl.sv - loopback controller queueing received bytes and replaying them to the transmitter
// Edge-detected rx pushes into a small FIFO; an FSM pops one byte at a time and runs the tx_val/busy handshake.
module uart_echo_ctrl #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_val,
    input  logic [7:0]            rx_data,
    input  logic                  busy,
    input  logic                  clr_err,
    output logic                  tx_val,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST    = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            rx_val_d;
    logic [TW-1:0]   to_cnt;

    logic            push;
    logic            pop;
    logic            full;
    logic            accept;

    // A full FIFO still takes a byte when a pop frees a slot on the same edge.
    always_comb begin
        push   = rx_val & ~rx_val_d;
        full   = (fifo_count == COUNT_FULL);
        pop    = (state == IDLE) && (fifo_count != '0) && !busy;
        accept = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_val_d   <= 1'b0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            rx_val_d <= rx_val;
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && !accept) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    // The clear is applied first so a timeout on the same edge keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            tx_val      <= 1'b0;
            tx_data     <= 8'h00;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (clr_err) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + PW'(1);
                        tx_val  <= 1'b1;
                        to_cnt  <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (busy) begin
                        tx_val <= 1'b0;
                        to_cnt <= '0;
                        state  <= WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        tx_val      <= 1'b0;
                        to_cnt      <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_val <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb/tb_uart_echo_ctrl.sv - self-checking bench for uart_echo_ctrl
// Transmitter is emulated on the falling clock edge; a scoreboard queue holds the bytes expected on tx.
module tb_uart_echo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_val;
    logic [7:0] rx_data;
    logic       busy;
    logic       clr_err;
    logic       tx_val;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       timeout_err;

    logic       force_busy = 1'b0;
    logic       busy_auto  = 1'b0;
    logic       auto_tx    = 1'b1;
    int         busy_len   = 10;

    assign busy = force_busy | busy_auto;

    uart_echo_ctrl #(
        .DEPTH_LOG2  (4),
        .BUSY_TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_val     (rx_val),
        .rx_data    (rx_data),
        .busy       (busy),
        .clr_err    (clr_err),
        .tx_val     (tx_val),
        .tx_data    (tx_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (auto_tx && tx_val && !busy_auto) begin
                busy_auto = 1'b1;
                repeat (busy_len) @(negedge clk);
                busy_auto = 1'b0;
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [4:0] exp_count;
        logic       exp_ovf;
        bit         exp_tx;
    } vec_t;

    vec_t       vecs [17];
    logic [7:0] sb [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         tx_starts = 0;
    int         last_fall = 0;
    bit         fall_pending = 1'b0;
    bit         in_xfer  = 1'b0;
    logic       tx_val_p = 1'b0;
    logic       busy_p   = 1'b0;
    logic [7:0] last_sent = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic sample();
        logic [31:0] exp_v;
        cyc++;
        if (!rst) begin
            last_sent    = 8'h00;
            in_xfer      = 1'b0;
            fall_pending = 1'b0;
        end
        if (!busy && busy_p) begin
            if (in_xfer) check("tx_data_hold", {24'h0, tx_data}, {24'h0, last_sent});
            fall_pending = in_xfer && (fifo_count != 5'd0);
            last_fall    = cyc;
            in_xfer      = 1'b0;
        end
        if (tx_val && !tx_val_p) begin
            tx_starts++;
            in_xfer = 1'b1;
            if (sb.size() > 0) exp_v = {24'h0, sb.pop_front()};
            else exp_v = 32'h100;
            check("tx_data", {24'h0, tx_data}, exp_v);
            check("tx_start_busy_low", {31'h0, busy}, 32'h0);
            last_sent = tx_data;
            if (fall_pending) begin
                check("idle_gap", cyc - last_fall, 32'd1);
                fall_pending = 1'b0;
            end
        end
        if (busy) check("tx_low_while_busy", {31'h0, tx_val}, 32'h0);
        tx_val_p = tx_val;
        busy_p   = busy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        if (expect_tx) sb.push_back(b);
        rx_data = b;
        rx_val  = 1'b1;
        step();
        rx_val  = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            idle = (sb.size() == 0) && !tx_val && !busy && (fifo_count == 5'd0);
            if (idle) break;
            step();
        end
        check("idle_reached", {31'h0, idle}, 32'h1);
    endtask

    initial begin
        int s0;
        int peak;
        int n;

        for (int i = 0; i < 17; i++) begin
            vecs[i].data      = 8'(i);
            vecs[i].exp_count = (i < 16) ? 5'(i + 1) : 5'd16;
            vecs[i].exp_ovf   = (i == 16);
            vecs[i].exp_tx    = (i < 16);
        end

        rst = 1'b0; rx_val = 1'b0; rx_data = 8'h00; clr_err = 1'b0;
        #1;
        check("rst_tx_val", {31'h0, tx_val}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_count", {27'h0, fifo_count}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        check("rst_timeout", {31'h0, timeout_err}, 32'h0);
        step(); step();
        rst = 1'b1;
        step();

        // single byte
        sb.push_back(8'hAC);
        rx_data = 8'hAC; rx_val = 1'b1;
        step();
        check("single_count_up", {27'h0, fifo_count}, 32'd1);
        rx_val = 1'b0;
        step();
        check("single_count_down", {27'h0, fifo_count}, 32'd0);
        check("single_tx_val", {31'h0, tx_val}, 32'h1);
        check("single_tx_data", {24'h0, tx_data}, 32'hAC);
        wait_idle(100);

        // held rx_val
        s0 = tx_starts; peak = 0;
        sb.push_back(8'h5A);
        rx_data = 8'h5A; rx_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        rx_val = 1'b0;
        step();
        wait_idle(100);
        check("held_peak", peak, 32'd1);
        check("held_tx_count", tx_starts - s0, 32'd1);

        // burst while transmitting
        s0 = tx_starts;
        push_byte(8'hF0, 1'b1);
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        wait_idle(200);
        check("burst_tx_count", tx_starts - s0, 32'd4);

        // overflow with busy held
        force_busy = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            push_byte(vecs[i].data, vecs[i].exp_tx);
            check("ovf_count", {27'h0, fifo_count}, {27'h0, vecs[i].exp_count});
            check("ovf_flag", {31'h0, overflow}, {31'h0, vecs[i].exp_ovf});
        end
        s0 = tx_starts;
        force_busy = 1'b0;
        wait_idle(600);
        check("ovf_tx_count", tx_starts - s0, 32'd16);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);

        // timeout and clear
        auto_tx = 1'b0;
        push_byte(8'h77, 1'b1);
        n = 0;
        while (tx_val && n < 20) begin
            n++;
            step();
        end
        check("timeout_tx_cycles", n, 32'd8);
        check("timeout_flag", {31'h0, timeout_err}, 32'h1);
        check("timeout_count", {27'h0, fifo_count}, 32'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_timeout", {31'h0, timeout_err}, 32'h0);
        check("clr_overflow", {31'h0, overflow}, 32'h0);
        auto_tx = 1'b1;
        step();

        // async reset mid-transfer
        push_byte(8'hC3, 1'b1);
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        check("pre_rst_count", {27'h0, fifo_count}, 32'd2);
        #3 rst = 1'b0;
        #1;
        check("arst_tx_val", {31'h0, tx_val}, 32'h0);
        check("arst_tx_data", {24'h0, tx_data}, 32'h0);
        check("arst_count", {27'h0, fifo_count}, 32'h0);
        check("arst_overflow", {31'h0, overflow}, 32'h0);
        check("arst_timeout", {31'h0, timeout_err}, 32'h0);
        step(); step();
        rst = 1'b1;
        s0 = tx_starts;
        repeat (30) step();
        check("post_rst_no_tx", tx_starts - s0, 32'd0);
        check("post_rst_count", {27'h0, fifo_count}, 32'd0);
        push_byte(8'h9E, 1'b1);
        wait_idle(100);
        check("post_rst_tx", tx_starts - s0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
